// File: rtl/mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : mc_pkg                                                     |
// | Purpose : Shared types and encodings for the multicycle MIPS control |
// |           unit: FSM state enum, opcode constants, ALU control codes, |
// |           ALU-B / next-PC mux encodings and aluop codes.             |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_lb    = 6'b100000;

  // ALU control encodings
  localparam logic [2:0] c_alu_add = 3'b010;
  localparam logic [2:0] c_alu_sub = 3'b110;
  localparam logic [2:0] c_alu_and = 3'b000;
  localparam logic [2:0] c_alu_or  = 3'b001;
  localparam logic [2:0] c_alu_slt = 3'b111;

  // aluop handed to the funct decoder
  localparam logic [1:0] c_aluop_add   = 2'b00;
  localparam logic [1:0] c_aluop_sub   = 2'b01;
  localparam logic [1:0] c_aluop_funct = 2'b10;

  // ALU B operand select
  localparam logic [1:0] c_srcb_rt     = 2'b00;
  localparam logic [1:0] c_srcb_four   = 2'b01;
  localparam logic [1:0] c_srcb_imm    = 2'b10;
  localparam logic [1:0] c_srcb_imm_sh = 2'b11;

  // Next-PC select
  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_aluout = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

  // States in which the FSM waits on the memory handshake
  function automatic logic is_mem_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_controller_aludec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : aludec                                                     |
// | Purpose : ALU control decoder. aluop 00 -> add, 01 -> sub, 10 ->     |
// |           decode from the R-type funct field.                        |
// | Ports   : funct[5:0]      in  - instruction bits [5:0]               |
// |           aluop[1:0]      in  - operation class from the FSM         |
// |           alucontrol[2:0] out - ALU operation                        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module aludec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = c_alu_add;
    case (aluop)
      c_aluop_add: alucontrol = c_alu_add;
      c_aluop_sub: alucontrol = c_alu_sub;
      default: begin
        case (funct)
          6'b100000: alucontrol = c_alu_add;
          6'b100010: alucontrol = c_alu_sub;
          6'b100100: alucontrol = c_alu_and;
          6'b100101: alucontrol = c_alu_or;
          6'b101010: alucontrol = c_alu_slt;
          default:   alucontrol = c_alu_and;
        endcase
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mc_controller                                              |
// | Purpose : Multicycle MIPS control unit. Sequences the shared         |
// |           datapath through per-instruction states, waits on the      |
// |           memory ready handshake and flags illegal opcodes and       |
// |           memory stall overruns.                                     |
// | Config  : MC_LB_EN - when defined, opcode 100000 decodes as LB;      |
// |           otherwise it traps and the byte-access outputs are 0.      |
// | Params  : MEM_WAIT_MAX - stall cycles on one access before           |
// |           mem_timeout is raised (must be >= 1).                      |
// | Ports   : clk, reset (async, active low)                             |
// |           op[5:0], funct[5:0], zero, mem_ready         - inputs      |
// |           iord, irwrite, pcen, memwrite, memtoreg, regdst, regwrite, |
// |           alusrca, alusrcb[1:0], pcsrc[1:0], alucontrol[2:0],        |
// |           readwritetype, chooseextend                  - datapath    |
// |           instr_retired, illegal_op, mem_timeout       - status      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module mc_controller #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       readwritetype,
  output logic       chooseextend,
  output logic       instr_retired,
  output logic       illegal_op,
  output logic       mem_timeout
);
  import mc_pkg::*;

  localparam int                 c_cnt_w    = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [c_cnt_w-1:0] c_wait_max = c_cnt_w'(MEM_WAIT_MAX);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  state_t             r_state;
  logic [c_cnt_w-1:0] r_stall_cnt;
  logic               r_illegal;
  logic               r_timeout;

  state_t     w_next;
  logic       w_iord, w_irwrite, w_pcwrite, w_branch, w_memwrite, w_memtoreg;
  logic       w_regdst, w_regwrite, w_alusrca, w_rwtype, w_chext, w_retired;
  logic [1:0] w_alusrcb, w_pcsrc, w_aluop;
  logic [2:0] w_alucontrol, w_aludec;
  logic       w_is_lb, w_stall;

`ifdef MC_LB_EN
  assign w_is_lb = (op == c_op_lb);
`else
  assign w_is_lb = 1'b0;
`endif

  assign w_aluop = (r_state == S_EXECUTE) ? c_aluop_funct :
                   (r_state == S_BRANCH)  ? c_aluop_sub   : c_aluop_add;

  aludec u_aludec (
    .funct      (funct),
    .aluop      (w_aluop),
    .alucontrol (w_aludec)
  );

  // A memory state with no ready can only stay put, so this alone marks
  // a consecutive stall cycle; anything else clears the counter.
  assign w_stall = is_mem_wait_state(r_state) && !mem_ready;

  always_comb begin
    w_next       = r_state;
    w_iord       = 1'b0;
    w_irwrite    = 1'b0;
    w_pcwrite    = 1'b0;
    w_branch     = 1'b0;
    w_memwrite   = 1'b0;
    w_memtoreg   = 1'b0;
    w_regdst     = 1'b0;
    w_regwrite   = 1'b0;
    w_alusrca    = 1'b0;
    w_rwtype     = 1'b0;
    w_chext      = 1'b0;
    w_retired    = 1'b0;
    w_alusrcb    = c_srcb_rt;
    w_pcsrc      = c_pcsrc_alu;
    w_alucontrol = 3'b000;
    case (r_state)
      S_FETCH: begin
        w_alusrcb    = c_srcb_four;
        w_alucontrol = c_alu_add;
        if (mem_ready) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alusrcb    = c_srcb_imm_sh;
        w_alucontrol = c_alu_add;
        case (op)
          c_op_lw, c_op_sw: w_next = S_MEMADR;
          c_op_rtype:       w_next = S_EXECUTE;
          c_op_beq:         w_next = S_BRANCH;
          c_op_addi:        w_next = S_ADDIEXEC;
          c_op_j:           w_next = S_JUMP;
          default:          w_next = w_is_lb ? S_MEMADR : S_TRAP;
        endcase
      end
      S_MEMADR, S_ADDIEXEC: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = c_srcb_imm;
        w_alucontrol = c_alu_add;
        if (r_state == S_ADDIEXEC) w_next = S_ADDIWB;
        else                       w_next = (op == c_op_sw) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_iord   = 1'b1;
        w_rwtype = w_is_lb;
        w_chext  = w_is_lb;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_chext    = w_is_lb;
        w_retired  = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        if (mem_ready) begin
          w_retired = 1'b1;
          w_next    = S_FETCH;
        end
      end
      S_EXECUTE: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = c_srcb_rt;
        w_alucontrol = w_aludec;
        w_next       = S_ALUWB;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_retired  = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = c_srcb_rt;
        w_alucontrol = w_aludec;
        w_pcsrc      = c_pcsrc_aluout;
        w_branch     = 1'b1;
        w_retired    = 1'b1;
        w_next       = S_FETCH;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_retired  = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        w_pcsrc   = c_pcsrc_jump;
        w_pcwrite = 1'b1;
        w_retired = 1'b1;
        w_next    = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_FETCH;
      r_stall_cnt <= '0;
      r_illegal   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
      if (w_stall) begin
        // Saturate; the flag is raised on the stall that reaches the limit.
        if (r_stall_cnt != c_wait_max) begin
          r_stall_cnt <= r_stall_cnt + c_cnt_one;
          if ((r_stall_cnt + c_cnt_one) == c_wait_max) r_timeout <= 1'b1;
        end
      end else begin
        r_stall_cnt <= '0;
      end
    end
  end

  // Reset is asynchronous, so outputs are gated directly by it to silence
  // the datapath in the same instant reset is asserted.
  assign iord          = reset & w_iord;
  assign irwrite       = reset & w_irwrite;
  assign pcen          = reset & (w_pcwrite | (w_branch & zero));
  assign memwrite      = reset & w_memwrite;
  assign memtoreg      = reset & w_memtoreg;
  assign regdst        = reset & w_regdst;
  assign regwrite      = reset & w_regwrite;
  assign alusrca       = reset & w_alusrca;
  assign alusrcb       = reset ? w_alusrcb    : 2'b00;
  assign pcsrc         = reset ? w_pcsrc      : 2'b00;
  assign alucontrol    = reset ? w_alucontrol : 3'b000;
  assign readwritetype = reset & w_rwtype;
  assign chooseextend  = reset & w_chext;
  assign instr_retired = reset & w_retired;
  assign illegal_op    = r_illegal;
  assign mem_timeout   = r_timeout;

endmodule
`default_nettype wire

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit that sequences the shared MIPS datapath (single memory, instruction/data registers, one ALU) through per-instruction state sequences. Decodes `op`/`funct` from the instruction register and drives every datapath enable and mux select each cycle. Waits on a memory ready handshake and supports the LB byte-load extension. Sits between the instruction register and the multicycle datapath, replacing the single-cycle `controller`.

## Interface
Parameters:
- `MEM_WAIT_MAX`, default 15: maximum number of stall cycles allowed on one memory access before `mem_timeout` is raised.

Ports:
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `op` input 6: instruction register bits [31:26].
- `funct` input 6: instruction register bits [5:0].
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes the current access this cycle.
- `iord` output 1: memory address select (0 = PC, 1 = ALUOut).
- `irwrite` output 1: load the instruction register.
- `pcen` output 1: PC load. Computed as `pcwrite | (branch & zero)`.
- `memwrite` output 1: memory write strobe.
- `memtoreg` output 1: register-file write data select (1 = data register).
- `regdst` output 1: write-register select (1 = rd).
- `regwrite` output 1: register-file write.
- `alusrca` output 1: ALU A select (0 = PC, 1 = rs).
- `alusrcb` output 2: ALU B select (00 rt, 01 constant 4, 10 signimm, 11 signimm<<2).
- `pcsrc` output 2: next-PC select (00 ALU, 01 ALUOut, 10 jump target).
- `alucontrol` output 3: ALU operation.
- `readwritetype` output 1: byte access.
- `chooseextend` output 1: sign-extend byte read data.
- `instr_retired` output 1: one-cycle pulse on the final cycle of each instruction.
- `illegal_op` output 1: sticky flag, set on an undecodable opcode.
- `mem_timeout` output 1: sticky flag, set on a memory stall overrun.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP, TRAP.
- FETCH:
  - Outputs `iord`=0, `alusrca`=0, `alusrcb`=01, `alucontrol`=add, `pcsrc`=00.
  - `irwrite` and `pcwrite` are asserted only in the cycle where `mem_ready`=1.
  - On `mem_ready`=1, go to DECODE; otherwise stay in FETCH.
- DECODE:
  - Outputs `alusrca`=0, `alusrcb`=11, `alucontrol`=add (branch-target precompute).
  - Transitions by `op`: LW/SW/LB → MEMADR; R-type → EXECUTE; BEQ → BRANCH; ADDI → ADDIEXEC; J → JUMP; any other opcode → TRAP.
- MEMADR: `alusrca`=1, `alusrcb`=10, add. SW → MEMWR; LW/LB → MEMRD.
- MEMRD:
  - `iord`=1.
  - LB additionally drives `readwritetype`=1 and `chooseextend`=1.
  - Wait for `mem_ready`, then go to MEMWB.
- MEMWB: `regdst`=0, `memtoreg`=1, `regwrite`=1. LB keeps `chooseextend`=1. Next state FETCH.
- MEMWR: `iord`=1, `memwrite`=1, held until `mem_ready`=1, then FETCH.
- EXECUTE: `alusrca`=1, `alusrcb`=00, `alucontrol` from the `aludec` funct decode (aluop=10). Next state ALUWB.
- ALUWB: `regdst`=1, `memtoreg`=0, `regwrite`=1. Next state FETCH.
- BRANCH: `alusrca`=1, `alusrcb`=00, sub, `pcsrc`=01, `branch`=1. Next state FETCH.
- ADDIEXEC is identical to MEMADR and goes to ADDIWB. ADDIWB: `regdst`=0, `regwrite`=1, then FETCH.
- JUMP: `pcsrc`=10, `pcwrite`=1. Next state FETCH.
- TRAP:
  - All strobes are 0 and `illegal_op`=1.
  - TRAP is absorbing; only reset leaves it.
- Strobes not listed for a state are 0. Mux selects not listed are 0.
- Stall counter:
  - Counts consecutive cycles with `mem_ready`=0 in FETCH, MEMRD and MEMWR; it is cleared whenever the state is left.
  - When the count reaches `MEM_WAIT_MAX`, `mem_timeout` is set (sticky) and the FSM keeps waiting.
  - The counter saturates and does not wrap.
- `instr_retired` pulses in MEMWB, ALUWB, ADDIWB and JUMP. In MEMWR and BRANCH it pulses in the cycle the state exits; for MEMWR that is the `mem_ready`=1 cycle. It never pulses in TRAP.

## Timing
- The state register is clocked on the rising edge. Outputs are combinational from the current state, `op`, `funct`, `zero` and `mem_ready`.
- While `reset`=0: state is FETCH, the stall counter is 0, `illegal_op`=0, `mem_timeout`=0, and every output is forced to 0.
- Reset asserted mid-instruction aborts it immediately with no further writes. The first cycle after reset release is FETCH.
- Latency with `mem_ready` tied to 1: LW/LB 5 cycles; R-type, SW and ADDI 4 cycles; BEQ and J 3 cycles. Each `mem_ready`=0 cycle in a memory state adds exactly one cycle.
- `mem_ready` is ignored in non-memory states.

## Configuration
- `MC_LB_EN` defined: opcode 100000 decodes as LB as described above.
- `MC_LB_EN` undefined:
  - 100000 is illegal and goes to TRAP.
  - `readwritetype` and `chooseextend` are tied to 0.

## Structure
- Package `mc_pkg` holds:
  - the state enum;
  - opcode constants (RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010, LB 100000);
  - the ALU control encodings (add 010, sub 110, and 000, or 001, slt 111);
  - the `alusrcb` and `pcsrc` select encodings.
- One sub-module: the existing `aludec`, instantiated for funct decode. Its aluop is 10 in EXECUTE, 01 in BRANCH and 00 otherwise.

## Test plan
- ADD (funct 100000) with `mem_ready`=1 → states FETCH, DECODE, EXECUTE, ALUWB. `regwrite`=1 and `regdst`=1 only in cycle 4; `instr_retired` is high in cycle 4.
- LW with `mem_ready` low for 3 cycles in MEMRD → 8 total cycles; `iord`=1 for the whole of MEMRD; exactly one `regwrite`.
- LB (op 100000) with `MC_LB_EN` defined → `chooseextend`=1 in MEMRD and MEMWB. With `MC_LB_EN` undefined → TRAP, `illegal_op`=1, no strobes thereafter.
- BEQ with `zero`=1 → `pcen`=1 in BRANCH with `pcsrc`=01. With `zero`=0 → `pcen`=0. Both take 3 cycles.
- SW with `mem_ready` held at 0 for 16 cycles → `mem_timeout` rises after 15 stall cycles. `memwrite` is held for all 16 cycles, and the FSM retires once `mem_ready`=1.
- `reset` pulsed low during MEMWR → all outputs 0 immediately. After release: FETCH, `iord`=0, and `irwrite` is asserted on the first cycle with `mem_ready`=1.
